// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the units, tens and hours digit stages.
//   SEG_0..SEG_9, SEG_BLANK : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   CW_DEFAULT              : default digit count width
//   seg_decode()            : digit value -> segment code, blank for values above 9
package clock_pkg;

  localparam int CW_DEFAULT = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [7:0] value);
    logic [6:0] seg;
    case (value)
      8'd0:    seg = SEG_0;
      8'd1:    seg = SEG_1;
      8'd2:    seg = SEG_2;
      8'd3:    seg = SEG_3;
      8'd4:    seg = SEG_4;
      8'd5:    seg = SEG_5;
      8'd6:    seg = SEG_6;
      8'd7:    seg = SEG_7;
      8'd8:    seg = SEG_8;
      8'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/carry_sync.sv
// carry_sync: brings an asynchronous carry level into the clk domain and turns
// each rising edge into a one-cycle increment request.
//   clk      : board clock
//   rst_n    : synchronous active-low reset
//   async_in : asynchronous carry level from the upstream stage
//   inc_edge : one-cycle pulse per rising edge of async_in, suppressed until armed
module carry_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic inc_edge
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] arm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      arm <= 2'd0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
      if (arm != 2'd3) arm <= arm + 2'd1;
    end
  end

  // The synchroniser leaves reset at 0, so a level that was already high
  // during reset looks like a fresh edge; the arm delay hides that edge.
  assign inc_edge = s2 & ~s3 & (arm == 2'd3);

endmodule

// File: rtl/tens_stage.sv
// tens_stage: modulo-MODULO digit counter fed by the units stage carry.
//   clk       : board clock
//   rst_n     : synchronous active-low reset
//   carry_in  : asynchronous carry level, each rising edge is one increment
//   step      : synchronous manual increment pulse
//   load_en   : synchronous load strobe (out-of-range load_val is ignored)
//   load_val  : value to load
//   count     : current digit value
//   Display   : active-low segments {g,f,e,d,c,b,a}
//   carry_out : one-cycle pulse when the digit wraps to 0
// Build option: TENS_BLANK_ZERO_EN blanks the display while count is 0.
module tens_stage
  import clock_pkg::*;
#(
  parameter int MODULO = 6,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          carry_in,
  input  logic          step,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic [6:0]    Display,
  output logic          carry_out
);

  logic          inc_edge;
  logic          inc;
  logic [CW-1:0] next_count;
  logic          next_carry;

  carry_sync u_carry_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (carry_in),
    .inc_edge (inc_edge)
  );

  // A coincident edge and step merge into a single increment.
  assign inc = inc_edge | step;

  function automatic logic [6:0] digit_seg(input logic [CW-1:0] value);
`ifdef TENS_BLANK_ZERO_EN
    if (value == '0) return SEG_BLANK;
`endif
    return seg_decode(8'(value));
  endfunction

  always_comb begin
    next_count = count;
    next_carry = 1'b0;
    if (load_en) begin
      if (load_val < CW'(MODULO)) next_count = load_val;
    end else if (inc) begin
      if (count == CW'(MODULO - 1)) begin
        next_count = '0;
        next_carry = 1'b1;
      end else begin
        next_count = count + CW'(1);
      end
    end
  end

  // Display is decoded from next_count so it changes on the same edge as count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      Display   <= digit_seg('0);
      carry_out <= 1'b0;
    end else begin
      count     <= next_count;
      Display   <= digit_seg(next_count);
      carry_out <= next_carry;
    end
  end

endmodule

// File: tb/tb_tens_stage.sv
module tb_tens_stage;

  localparam int MOD = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       carry_in;
  logic       step;
  logic       load_en;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [6:0] Display;
  logic       carry_out;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int doubles  = 0;
  logic prev_co = 1'b0;

  always #5 clk = ~clk;

  tens_stage #(.MODULO(MOD), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .carry_in  (carry_in),
    .step      (step),
    .load_en   (load_en),
    .load_val  (load_val),
    .count     (count),
    .Display   (Display),
    .carry_out (carry_out)
  );

  // Carry pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (carry_out === 1'b1) pulses++;
    if (carry_out === 1'b1 && prev_co === 1'b1) doubles++;
    prev_co = carry_out;
  end

  function automatic logic [6:0] exp_seg(input int v);
`ifdef TENS_BLANK_ZERO_EN
    if (v == 0) return 7'b1111111;
`endif
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input int v);
    chk({tag, "_count"}, 32'(count), 32'(v));
    chk({tag, "_disp"}, 32'(Display), 32'(exp_seg(v)));
  endtask

  int model_cnt;
  int exp_pulses;
  int p0;
  int op;
  int lv;

  initial begin
    rst_n = 1'b0; carry_in = 1'b0; step = 1'b0; load_en = 1'b0; load_val = '0;
    cyc(3);
    chk_digit("reset", 0);
    chk("reset_carry_out", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Five carry edges, 10 clocks apart
    p0 = pulses;
    for (int i = 1; i <= 5; i++) begin
      carry_in = 1'b1; cyc(5);
      carry_in = 1'b0; cyc(5);
      chk_digit("carry_rise", i);
    end
    chk("disp_five", 32'(Display), 32'(7'b0010010));
    chk("no_carry_before_wrap", 32'(pulses - p0), 32'd0);

    // Sixth edge: exact latency of wrap
    p0 = pulses;
    carry_in = 1'b1;
    cyc(1);
    chk("wrap_edge_k_co", 32'(carry_out), 32'd0);
    chk("wrap_edge_k_cnt", 32'(count), 32'd5);
    cyc(1);
    chk("wrap_edge_k1_co", 32'(carry_out), 32'd0);
    chk("wrap_edge_k1_cnt", 32'(count), 32'd5);
    cyc(1);
    chk("wrap_edge_k2_co", 32'(carry_out), 32'd1);
    chk_digit("wrap_edge_k2", 0);
    cyc(1);
    chk("wrap_edge_k3_co", 32'(carry_out), 32'd0);
    cyc(4);
    chk("wrap_single_pulse", 32'(pulses - p0), 32'd1);

    // Carry held high across reset, with count nonzero before reset
    step = 1'b1; cyc(1); step = 1'b0;
    chk_digit("step_before_reset", 1);
    rst_n = 1'b0; cyc(3);
    chk_digit("reset_mid_count", 0);
    rst_n = 1'b1;
    cyc(20);
    chk_digit("held_carry_no_inc", 0);
    carry_in = 1'b0; cyc(5);
    chk_digit("held_carry_release", 0);

    // Load beats a coincident step; out-of-range load ignored
    load_en = 1'b1; load_val = 4'd4; step = 1'b1;
    cyc(1);
    load_en = 1'b0; step = 1'b0;
    chk_digit("load_over_step", 4);
    chk("load_no_carry", 32'(carry_out), 32'd0);
    cyc(3);
    load_en = 1'b1; load_val = 4'd7; cyc(1); load_en = 1'b0;
    chk_digit("load_out_of_range", 4);
    load_en = 1'b1; load_val = 4'd5; cyc(1); load_en = 1'b0;
    chk_digit("load_five", 5);

    // Step coinciding with the synchronised edge at count 5
    p0 = pulses;
    carry_in = 1'b1;
    cyc(2);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("coincide_co", 32'(carry_out), 32'd1);
    chk_digit("coincide_wrap", 0);
    cyc(4);
    chk_digit("coincide_settle", 0);
    chk("coincide_one_pulse", 32'(pulses - p0), 32'd1);
    carry_in = 1'b0; cyc(5);

    // Display after reset then one step (blanking build shows blank at 0)
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    chk("post_reset_disp", 32'(Display), 32'(exp_seg(0)));
    cyc(5);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("one_step_disp", 32'(Display), 32'(7'b1111001));

    // Randomised operations against a digit-level model
    model_cnt  = 1;
    exp_pulses = 0;
    p0 = pulses;
    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        carry_in = 1'b1; cyc(4); carry_in = 1'b0; cyc(4);
        if (model_cnt == MOD - 1) begin model_cnt = 0; exp_pulses++; end
        else model_cnt++;
      end else if (op == 1) begin
        step = 1'b1; cyc(1); step = 1'b0; cyc(4);
        if (model_cnt == MOD - 1) begin model_cnt = 0; exp_pulses++; end
        else model_cnt++;
      end else begin
        lv = int'($urandom_range(0, 15));
        load_val = 4'(lv);
        load_en = 1'b1; cyc(1); load_en = 1'b0; cyc(4);
        if (lv < MOD) model_cnt = lv;
      end
      chk_digit("random", model_cnt);
    end
    chk("random_pulses", 32'(pulses - p0), 32'(exp_pulses));
    chk("no_double_pulse", 32'(doubles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
